// File: rtl/keccak_round_seq.sv
// rtl/keccak_round_seq.sv - round sequencer for 2-rounds-per-cycle Keccak-f, with iota lane expansion
module keccak_round_seq #(
    parameter int N_STEPS = 12,
    parameter int LANE_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N_STEPS-1:0] step_onehot,
    input  logic [6:0]         rc1_c,
    input  logic [6:0]         rc2_c,
    output logic [LANE_W-1:0]  rc1_lane,
    output logic [LANE_W-1:0]  rc2_lane,
    output logic               perm_load,
    output logic               perm_en,
    output logic               perm_last,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_STEPS-1:0] step_q, step_d;
    logic               load_q, load_d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        load_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_RUN;
                    step_d    = '0;
                    step_d[0] = 1'b1;
                    load_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (step_q[N_STEPS-1]) begin
                    state_d = S_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q << 1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            load_q  <= load_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign perm_en     = (state_q == S_RUN);
    assign perm_last   = perm_en & step_q[N_STEPS-1];
    assign out_valid   = (state_q == S_DONE);
    assign perm_load   = load_q;
    assign step_onehot = step_q;

    // Compressed bit j lands on lane bit 2^j-1; every other lane bit is zero.
    logic [LANE_W-1:0] rc1_x, rc2_x;

    for (genvar i = 0; i < LANE_W; i++) begin : g_lane
        if ((((i + 1) & i) == 0) && ($clog2(i + 1) < 7)) begin : g_rc
            assign rc1_x[i] = rc1_c[$clog2(i + 1)];
            assign rc2_x[i] = rc2_c[$clog2(i + 1)];
        end else begin : g_zero
            assign rc1_x[i] = 1'b0;
            assign rc2_x[i] = 1'b0;
        end
    end

    assign rc1_lane = perm_en ? rc1_x : '0;
    assign rc2_lane = perm_en ? rc2_x : '0;

endmodule

// File: tb/tb_keccak_round_seq.sv
// tb/tb_keccak_round_seq.sv - scoreboard bench for keccak_round_seq (64-bit and 16-bit lane instances)
module tb_keccak_round_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  rc1_c, rc2_c;

    logic        in_ready_a, perm_load_a, perm_en_a, perm_last_a, out_valid_a;
    logic [11:0] step_a;
    logic [63:0] rc1_a, rc2_a;

    logic        in_ready_b, perm_load_b, perm_en_b, perm_last_b, out_valid_b;
    logic [11:0] step_b;
    logic [15:0] rc1_b, rc2_b;

    keccak_round_seq u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .step_onehot(step_a), .rc1_c(rc1_c), .rc2_c(rc2_c),
        .rc1_lane(rc1_a), .rc2_lane(rc2_a), .perm_load(perm_load_a),
        .perm_en(perm_en_a), .perm_last(perm_last_a),
        .out_valid(out_valid_a), .out_ready(out_ready)
    );

    keccak_round_seq #(.N_STEPS(12), .LANE_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .step_onehot(step_b), .rc1_c(rc1_c), .rc2_c(rc2_c),
        .rc1_lane(rc1_b), .rc2_lane(rc2_b), .perm_load(perm_load_b),
        .perm_en(perm_en_b), .perm_last(perm_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [11:0] step;
        logic        load;
        logic        last;
        logic [63:0] l1, l2;
        logic [15:0] s1, s2;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   cyc_n = 0;
    bit   bb_mode = 0;
    int   bb_last = -1;
    logic rst_smp = 1'b1;
    bit   prev_ov = 0, prev_or = 0, prev_last = 0, prev_acc = 0;

    // Directed compressed-constant table and hand-expanded lanes
    function automatic logic [6:0] rcv(int i);
        case (i)
            0: return 7'h01;
            1: return 7'h1A;
            2: return 7'h7F;
            3: return 7'h40;
            4: return 7'h00;
            default: return 7'h55;
        endcase
    endfunction

    function automatic logic [63:0] e64(int i);
        case (i)
            0: return 64'h0000_0000_0000_0001;
            1: return 64'h0000_0000_0000_8082;
            2: return 64'h8000_0000_8000_808B;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_0000_0000;
            default: return 64'h8000_0000_0000_8009;
        endcase
    endfunction

    function automatic logic [15:0] e16(int i);
        case (i)
            0: return 16'h0001;
            1: return 16'h8082;
            2: return 16'h808B;
            3: return 16'h0000;
            4: return 16'h0000;
            default: return 16'h8009;
        endcase
    endfunction

    always_comb begin
        rc1_c = 7'h7F;
        rc2_c = 7'h55;
        for (int k = 0; k < 12; k++) begin
            if (step_a[k]) begin
                rc1_c = rcv(k % 6);
                rc2_c = rcv((k + 1) % 6);
            end
        end
    end

    always @(posedge clk) rst_smp <= reset;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (rst_smp) begin
            chk("rst_in_ready", in_ready_a, 1);
            chk("rst_out_valid", out_valid_a, 0);
            chk("rst_perm_en", perm_en_a, 0);
            chk("rst_step", step_a, 0);
        end
        chk("inst_agree_en", perm_en_b, perm_en_a);
        if (prev_acc) chk("load_after_accept", perm_load_a, 1);
        if (prev_ov && !prev_or && !rst_smp) chk("out_valid_held", out_valid_a, 1);
        if (perm_en_a) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                chk("unexpected_step", step_a, 0);
            end else begin
                e = exp_q.pop_front();
                chk("step_onehot", step_a, e.step);
                chk("perm_load", perm_load_a, e.load);
                chk("perm_last", perm_last_a, e.last);
                chk("rc1_lane64", rc1_a, e.l1);
                chk("rc2_lane64", rc2_a, e.l2);
                chk("rc1_lane16", rc1_b, e.s1);
                chk("rc2_lane16", rc2_b, e.s2);
            end
            chk("run_in_ready", in_ready_a, 0);
            if (perm_load_a && bb_mode) begin
                if (bb_last >= 0) chk("b2b_spacing", cyc_n - bb_last, 14);
                bb_last = cyc_n;
            end
        end else begin
            chk("idle_step", step_a, 0);
            chk("idle_load_last", {perm_load_a, perm_last_a}, 0);
            chk("idle_lanes", rc1_a | rc2_a | rc1_b | rc2_b, 0);
        end
        if (out_valid_a) begin
            chk("done_in_ready", in_ready_a, 0);
            if (!prev_ov) chk("out_valid_after_last", prev_last, 1);
        end
        if (out_valid_a && out_ready) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                chk("unexpected_done", out_valid_a, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_event", out_valid_a, 1);
                done_cnt++;
            end
        end
        prev_ov   = out_valid_a;
        prev_or   = out_ready;
        prev_last = perm_last_a;
        prev_acc  = in_valid && in_ready_a && !reset;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input int nsteps);
        exp_t e;
        for (int k = 0; k < nsteps; k++) begin
            e.is_done = 0;
            e.step    = 12'(1 << k);
            e.load    = (k == 0);
            e.last    = (k == 11);
            e.l1      = e64(k % 6);
            e.l2      = e64((k + 1) % 6);
            e.s1      = e16(k % 6);
            e.s2      = e16((k + 1) % 6);
            exp_q.push_back(e);
        end
        if (nsteps == 12) begin
            e = '{is_done: 1, step: 0, load: 0, last: 0, l1: 0, l2: 0, s1: 0, s2: 0};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && done_cnt < target; i++) cyc();
        if (done_cnt < target) chk("timeout_done", done_cnt, target);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Single transaction, consumer always ready
        out_ready = 1'b1;
        push_tx(12);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_done(1);
        repeat (2) cyc();

        // Stalled consumer with in_valid held, then release and immediate re-accept
        out_ready = 1'b0;
        push_tx(12);
        in_valid = 1'b1;
        cyc();
        for (int i = 0; i < 40 && !out_valid_a; i++) cyc();
        if (!out_valid_a) chk("timeout_out_valid", out_valid_a, 1);
        repeat (5) cyc();
        push_tx(12);
        out_ready = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        wait_done(3);
        repeat (2) cyc();

        // Reset during step 5 drops the permutation
        push_tx(6);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (20) cyc();

        // Back-to-back accepts with in_valid held
        bb_mode = 1;
        bb_last = -1;
        push_tx(12);
        push_tx(12);
        push_tx(12);
        in_valid = 1'b1;
        wait_done(6);
        in_valid = 1'b0;
        bb_mode  = 0;
        repeat (3) cyc();

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
